// File: rtl/pixel_readout_pkg.sv
// Shared types and helpers for the pixel readout path.
//   meter_state_t  : measurement FSM states
//   timeout_count  : saturation value of a COUNT_BITS-wide period counter
package pixel_readout_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ARM,
        MEASURE,
        DONE
    } meter_state_t;

    // All-ones value of a bits-wide counter (bits < 32).
    function automatic int unsigned timeout_count(input int unsigned bits);
        return (32'd1 << bits) - 32'd1;
    endfunction

endpackage

// File: rtl/pixel_period_meter_edge_sync_detect.sv
// Synchroniser plus rising-edge detector for an asynchronous square wave.
//   CLK       in  system clock
//   RST_N     in  synchronous, active-low reset
//   async_in  in  asynchronous input
//   level     out synchronised level
//   rise      out 1-cycle pulse on each synchronised rising edge
module edge_sync_detect #(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic CLK,
    input  logic RST_N,
    input  logic async_in,
    output logic level,
    output logic rise
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   prev_q;

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            sync_q <= '0;
            prev_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], async_in};
            prev_q <= sync_q[SYNC_STAGES-1];
        end
    end

    assign level = sync_q[SYNC_STAGES-1];
    assign rise  = level & ~prev_q;

endmodule

// File: rtl/pixel_period_meter.sv
// Measures the period of FREQ_IN in CLK cycles, averaged over 2**AVG_LOG2
// consecutive rising-edge periods, started by START and returned on a
// VALID/READY handshake. No edge within 2**COUNT_BITS-1 cycles ends the
// measurement with TIMEOUT=1 and PERIOD_OUT all ones.
//   CLK, RST_N       clock, synchronous active-low reset
//   FREQ_IN          asynchronous pixel square wave
//   START            1-cycle request, honoured only in IDLE
//   BUSY             high in ARM, MEASURE and DONE
//   VALID / READY    result handshake
//   PERIOD_OUT       averaged period (held until the next result)
//   TIMEOUT          no edge within the timeout window
module pixel_period_meter
    import pixel_readout_pkg::*;
#(
    parameter int unsigned COUNT_BITS  = 16,
    parameter int unsigned AVG_LOG2    = 2,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic                  CLK,
    input  logic                  RST_N,
    input  logic                  FREQ_IN,
    input  logic                  START,
    output logic                  BUSY,
    output logic                  VALID,
    input  logic                  READY,
    output logic [COUNT_BITS-1:0] PERIOD_OUT,
    output logic                  TIMEOUT
);

    localparam int unsigned ACC_BITS = COUNT_BITS + AVG_LOG2;
    localparam int unsigned N_BITS   = AVG_LOG2 + 1;
    localparam logic [COUNT_BITS-1:0] CNT_MAX = COUNT_BITS'(timeout_count(COUNT_BITS));
    localparam logic [COUNT_BITS-1:0] CNT_ONE = COUNT_BITS'(1);
    localparam logic [N_BITS-1:0]     N_LAST  = N_BITS'((1 << AVG_LOG2) - 1);

    meter_state_t          state_q, state_d;
    logic [COUNT_BITS-1:0] cnt_q, cnt_d;
    logic [ACC_BITS-1:0]   acc_q, acc_d, acc_sum;
    logic [N_BITS-1:0]     n_q, n_d;
    logic [COUNT_BITS-1:0] period_q, period_d;
    logic                  timeout_q, timeout_d;
    logic                  cnt_sat;
    logic                  rise;
    logic                  sync_level_unused;

    edge_sync_detect #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_sync (
        .CLK      (CLK),
        .RST_N    (RST_N),
        .async_in (FREQ_IN),
        .level    (sync_level_unused),
        .rise     (rise)
    );

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            acc_q     <= '0;
            n_q       <= '0;
            period_q  <= '0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            acc_q     <= acc_d;
            n_q       <= n_d;
            period_q  <= period_d;
            timeout_q <= timeout_d;
        end
    end

    // The counter restarts at 1 on the cycle after each rise, so at the
    // next rise it holds exactly the number of cycles between the two.
    // START uses the same restart value, giving a timeout window of
    // CNT_MAX cycles in ARM as well.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        acc_d     = acc_q;
        n_d       = n_q;
        period_d  = period_q;
        timeout_d = timeout_q;
        cnt_sat   = (cnt_q == CNT_MAX);
        acc_sum   = acc_q + ACC_BITS'(cnt_q);

        case (state_q)
            IDLE: begin
                if (START) begin
                    state_d = ARM;
                    cnt_d   = CNT_ONE;
                end
            end
            ARM: begin
                if (rise) begin
                    state_d = MEASURE;
                    cnt_d   = CNT_ONE;
                    acc_d   = '0;
                    n_d     = '0;
                end else if (cnt_sat) begin
                    state_d   = DONE;
                    period_d  = '1;
                    timeout_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            MEASURE: begin
                // A rise in the saturating cycle is still a valid period.
                if (rise) begin
                    cnt_d = CNT_ONE;
                    acc_d = acc_sum;
                    n_d   = n_q + N_BITS'(1);
                    if (n_q == N_LAST) begin
                        state_d   = DONE;
                        period_d  = acc_sum[AVG_LOG2 +: COUNT_BITS];
                        timeout_d = 1'b0;
                    end
                end else if (cnt_sat) begin
                    state_d   = DONE;
                    period_d  = '1;
                    timeout_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            DONE: begin
                if (READY) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign BUSY       = (state_q != IDLE);
    assign VALID      = (state_q == DONE);
    assign PERIOD_OUT = period_q;
    assign TIMEOUT    = timeout_q;

endmodule

// File: tb/tb_pixel_period_meter.sv
// Directed bench for pixel_period_meter. Instance a: COUNT_BITS=16,
// AVG_LOG2=2, SYNC_STAGES=2. Instance b: COUNT_BITS=8, AVG_LOG2=0,
// SYNC_STAGES=3 (single-period mode and a short timeout window).
module tb_pixel_period_meter;

    logic        CLK = 1'b0;
    logic        RST_N;
    logic        start_a, ready_a, freq_a;
    logic        busy_a, valid_a, timeout_a;
    logic [15:0] period_a;
    logic        start_b, ready_b, freq_b;
    logic        busy_b, valid_b, timeout_b;
    logic [7:0]  period_b;

    int total = 0;
    int bad   = 0;

    always #5 CLK = ~CLK;

    pixel_period_meter #(
        .COUNT_BITS (16),
        .AVG_LOG2   (2),
        .SYNC_STAGES(2)
    ) u_dut_a (
        .CLK       (CLK),
        .RST_N     (RST_N),
        .FREQ_IN   (freq_a),
        .START     (start_a),
        .BUSY      (busy_a),
        .VALID     (valid_a),
        .READY     (ready_a),
        .PERIOD_OUT(period_a),
        .TIMEOUT   (timeout_a)
    );

    pixel_period_meter #(
        .COUNT_BITS (8),
        .AVG_LOG2   (0),
        .SYNC_STAGES(3)
    ) u_dut_b (
        .CLK       (CLK),
        .RST_N     (RST_N),
        .FREQ_IN   (freq_b),
        .START     (start_b),
        .BUSY      (busy_b),
        .VALID     (valid_b),
        .READY     (ready_b),
        .PERIOD_OUT(period_b),
        .TIMEOUT   (timeout_b)
    );

    typedef struct {
        bit          sel;     // 0 = instance a, 1 = instance b
        int          p[4];    // gaps between rising edges (b uses p[0] only)
        bit          ready;   // READY already high when VALID rises
        logic [31:0] exp;     // expected PERIOD_OUT
    } vec_t;

    vec_t vecs[10];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic logic get_valid(input bit sel);
        return sel ? valid_b : valid_a;
    endfunction
    function automatic logic get_busy(input bit sel);
        return sel ? busy_b : busy_a;
    endfunction
    function automatic logic get_timeout(input bit sel);
        return sel ? timeout_b : timeout_a;
    endfunction
    function automatic logic [31:0] get_period(input bit sel);
        return sel ? 32'(period_b) : 32'(period_a);
    endfunction

    task automatic set_freq(input bit sel, input logic v);
        if (sel) freq_b = v;
        else     freq_a = v;
    endtask
    task automatic set_start(input bit sel, input logic v);
        if (sel) start_b = v;
        else     start_a = v;
    endtask
    task automatic set_ready(input bit sel, input logic v);
        if (sel) ready_b = v;
        else     ready_a = v;
    endtask

    // FREQ_IN is high on entry; ends with the next rising edge just driven.
    task automatic edge_gap(input bit sel, input int p);
        int h;
        h = p / 2;
        repeat (h) @(negedge CLK);
        set_freq(sel, 1'b0);
        repeat (p - h) @(negedge CLK);
        set_freq(sel, 1'b1);
    endtask

    // Counts posedges until VALID is seen (sampled 1 time unit after each edge).
    task automatic wait_valid(input bit sel, input int limit, output int edges);
        edges = -1;
        for (int i = 1; i <= limit; i++) begin
            @(posedge CLK);
            #1;
            if (get_valid(sel)) begin
                edges = i;
                break;
            end
        end
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        int e;
        int ngaps;
        ngaps = v.sel ? 1 : 4;
        @(negedge CLK);
        set_start(v.sel, 1'b1);
        set_ready(v.sel, v.ready);
        @(negedge CLK);
        set_start(v.sel, 1'b0);
        @(negedge CLK);
        set_freq(v.sel, 1'b1);
        for (int g = 0; g < ngaps; g++) edge_gap(v.sel, v.p[g]);
        wait_valid(v.sel, 50, e);
        chk($sformatf("v%0d_latency", idx), e, v.sel ? 32'd4 : 32'd3);
        chk($sformatf("v%0d_period", idx), get_period(v.sel), v.exp);
        chk($sformatf("v%0d_timeout", idx), 32'(get_timeout(v.sel)), 32'd0);
        chk($sformatf("v%0d_busy", idx), 32'(get_busy(v.sel)), 32'd1);
        if (!v.ready) begin
            @(negedge CLK);
            set_ready(v.sel, 1'b1);
        end
        @(posedge CLK);
        #1;
        chk($sformatf("v%0d_valid_drop", idx), 32'(get_valid(v.sel)), 32'd0);
        chk($sformatf("v%0d_idle", idx), 32'(get_busy(v.sel)), 32'd0);
        chk($sformatf("v%0d_period_held", idx), get_period(v.sel), v.exp);
        @(negedge CLK);
        set_ready(v.sel, 1'b0);
        set_freq(v.sel, 1'b0);
        repeat (5) @(negedge CLK);
    endtask

    initial begin
        int  e;
        bit  stable;
        vec_t v5;

        vecs[0] = '{1'b0, '{100, 100, 100, 100}, 1'b1, 32'd100};
        vecs[1] = '{1'b0, '{100, 100, 100, 103}, 1'b0, 32'd100};  // 403>>2
        vecs[2] = '{1'b0, '{10, 20, 30, 41},     1'b1, 32'd25};   // 101>>2
        vecs[3] = '{1'b0, '{2, 2, 2, 2},         1'b0, 32'd2};    // fastest edges
        vecs[4] = '{1'b0, '{3, 4, 5, 7},         1'b1, 32'd4};    // 19>>2
        vecs[5] = '{1'b0, '{500, 300, 200, 1003}, 1'b0, 32'd500}; // 2003>>2
        vecs[6] = '{1'b1, '{37, 0, 0, 0},        1'b1, 32'd37};
        vecs[7] = '{1'b1, '{2, 0, 0, 0},         1'b0, 32'd2};
        vecs[8] = '{1'b1, '{254, 0, 0, 0},       1'b1, 32'd254};
        vecs[9] = '{1'b1, '{255, 0, 0, 0},       1'b0, 32'd255};  // rise beats saturation

        RST_N   = 1'b0;
        start_a = 1'b0; ready_a = 1'b0; freq_a = 1'b0;
        start_b = 1'b0; ready_b = 1'b0; freq_b = 1'b0;
        repeat (3) @(negedge CLK);
        chk("rst_busy_a",    32'(busy_a),    32'd0);
        chk("rst_valid_a",   32'(valid_a),   32'd0);
        chk("rst_period_a",  32'(period_a),  32'd0);
        chk("rst_timeout_a", 32'(timeout_a), 32'd0);
        chk("rst_busy_b",    32'(busy_b),    32'd0);
        chk("rst_period_b",  32'(period_b),  32'd0);
        RST_N = 1'b1;
        repeat (3) @(negedge CLK);

        for (int i = 0; i < 10; i++) run_vec(vecs[i], i);

        // Result held while READY is low; START ignored outside IDLE.
        @(negedge CLK);
        start_a = 1'b1;
        ready_a = 1'b0;
        @(negedge CLK);
        start_a = 1'b0;
        @(negedge CLK);
        freq_a = 1'b1;
        for (int g = 0; g < 4; g++) edge_gap(1'b0, 100);
        wait_valid(1'b0, 50, e);
        chk("hold_latency", e, 32'd3);
        stable = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge CLK);
            start_a = (i % 3 == 0);
            @(posedge CLK);
            #1;
            if (!(valid_a === 1'b1 && busy_a === 1'b1 && period_a === 16'd100 && timeout_a === 1'b0))
                stable = 1'b0;
        end
        chk("hold_stable", 32'(stable), 32'd1);
        @(negedge CLK);
        start_a = 1'b0;
        ready_a = 1'b1;
        @(posedge CLK);
        #1;
        chk("hold_valid_drop", 32'(valid_a), 32'd0);
        chk("hold_busy_drop",  32'(busy_a),  32'd0);
        @(negedge CLK);
        ready_a = 1'b0;
        @(posedge CLK);
        #1;
        chk("start_ignored", 32'(busy_a), 32'd0);
        @(negedge CLK);
        freq_a = 1'b0;
        repeat (5) @(negedge CLK);

        // Dead pixel: no edges at all, timeout from ARM.
        start_a = 1'b1;
        @(negedge CLK);
        start_a = 1'b0;
        wait_valid(1'b0, 70000, e);
        chk("arm_timeout_cycles", e, 32'd65535);
        chk("arm_timeout_flag",   32'(timeout_a), 32'd1);
        chk("arm_timeout_period", 32'(period_a),  32'h0000FFFF);
        @(negedge CLK);
        ready_a = 1'b1;
        @(negedge CLK);
        ready_a = 1'b0;

        // One edge then stuck high: timeout from MEASURE on instance b.
        start_b = 1'b1;
        @(negedge CLK);
        start_b = 1'b0;
        @(negedge CLK);
        freq_b = 1'b1;
        wait_valid(1'b1, 400, e);
        chk("meas_timeout_cycles", e, 32'd259);
        chk("meas_timeout_flag",   32'(timeout_b), 32'd1);
        chk("meas_timeout_period", 32'(period_b),  32'd255);
        @(negedge CLK);
        ready_b = 1'b1;
        freq_b  = 1'b0;
        @(negedge CLK);
        ready_b = 1'b0;

        // Reset in the middle of MEASURE, then a normal measurement.
        @(negedge CLK);
        start_a = 1'b1;
        @(negedge CLK);
        start_a = 1'b0;
        @(negedge CLK);
        freq_a = 1'b1;
        edge_gap(1'b0, 100);
        repeat (10) @(negedge CLK);
        chk("pre_reset_busy", 32'(busy_a), 32'd1);
        RST_N = 1'b0;
        @(posedge CLK);
        #1;
        chk("mid_rst_busy",    32'(busy_a),    32'd0);
        chk("mid_rst_valid",   32'(valid_a),   32'd0);
        chk("mid_rst_period",  32'(period_a),  32'd0);
        chk("mid_rst_timeout", 32'(timeout_a), 32'd0);
        @(negedge CLK);
        RST_N  = 1'b1;
        freq_a = 1'b0;
        repeat (3) @(negedge CLK);
        v5 = '{1'b0, '{100, 100, 100, 100}, 1'b1, 32'd100};
        run_vec(v5, 10);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
